// File: rtl/qed_dup_sequencer_if.sv
// Purpose: bundles the QED sequencer's control inputs and its status outputs.
// Latency: none; wires only.
// Backpressure: none; stall_IF is carried as a plain level signal.
// Ports:
//   Inputs to the sequencer: ena, stall_IF, fetch_vld, vld_out, force_dup.
//   Outputs from the sequencer: exec_dup, hold_fetch, qed_check, orig_cnt, dup_cnt.
// Modports:
//   slave  - the sequencer side.
//   master - the driver side, e.g. a fetch unit or a testbench.
interface qed_dup_sequencer_if;
    logic       ena;
    logic       stall_IF;
    logic       fetch_vld;
    logic       vld_out;
    logic       force_dup;
    logic       exec_dup;
    logic       hold_fetch;
    logic       qed_check;
    logic [4:0] orig_cnt;
    logic [4:0] dup_cnt;

    modport slave (
        input  ena, stall_IF, fetch_vld, vld_out, force_dup,
        output exec_dup, hold_fetch, qed_check, orig_cnt, dup_cnt
    );

    modport master (
        output ena, stall_IF, fetch_vld, vld_out, force_dup,
        input  exec_dup, hold_fetch, qed_check, orig_cnt, dup_cnt
    );
endinterface

// File: rtl/qed_dup_sequencer.sv
// Purpose: sequences QED batches; each batch runs originals, then an equal number of duplicates, then a pipeline drain.
// Latency: every output is registered, so it reflects the state one clock after the accept event that caused it.
// Backpressure: stall_IF blocks the original and duplicate accepts. It does not block the drain, which always lasts DRAIN_CYCLES.
// Ports:
//   clk - the single clock.
//   rst - asynchronous reset, active low.
//   bus - the qed_dup_sequencer_if slave modport.
module qed_dup_sequencer #(
    parameter int MAX_ORIG     = 16,   // originals per batch, 1..31
    parameter int DRAIN_CYCLES = 5     // drain length after duplicates, 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    qed_dup_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ORIG  = 2'd1,
        S_DUP   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [4:0] MAX_C      = 5'(MAX_ORIG);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_q,      state_d;
    logic [4:0] orig_cnt_q,   orig_cnt_d;
    logic [4:0] dup_cnt_q,    dup_cnt_d;
    logic [3:0] drain_q,      drain_d;
    logic       exec_dup_q,   exec_dup_d;
    logic       hold_fetch_q, hold_fetch_d;
    logic       qed_check_q,  qed_check_d;

    logic       acc_o;
    logic       acc_d;
    logic [4:0] orig_upd;     // orig_cnt including this cycle's accept
    logic [4:0] dup_upd;

    always_comb begin
        acc_o = bus.fetch_vld & ~bus.stall_IF;
        acc_d = bus.vld_out   & ~bus.stall_IF;

        // The saturation guards keep the counters from wrapping even if the
        // handshake misbehaves.
        orig_upd = (acc_o && (orig_cnt_q < MAX_C))     ? orig_cnt_q + 5'd1 : orig_cnt_q;
        dup_upd  = (acc_d && (dup_cnt_q  < orig_cnt_q)) ? dup_cnt_q  + 5'd1 : dup_cnt_q;

        state_d    = state_q;
        orig_cnt_d = orig_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        drain_d    = drain_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ena) begin
                    state_d    = S_ORIG;
                    orig_cnt_d = 5'd0;
                    dup_cnt_d  = 5'd0;
                end
            end
            S_ORIG: begin
                orig_cnt_d = orig_upd;
                // Once a batch holds at least one original it is always
                // completed: a full batch, force_dup, or a dropped ena all
                // lead to DUP.
                if ((acc_o && (orig_upd == MAX_C)) ||
                    ((orig_upd != 5'd0) && (bus.force_dup || !bus.ena))) begin
                    state_d = S_DUP;
                end else if (!bus.ena) begin
                    state_d = S_IDLE;
                end
            end
            S_DUP: begin
                dup_cnt_d = dup_upd;
                if (acc_d && (dup_upd == orig_cnt_q)) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'd0) begin
                    if (bus.ena) begin
                        state_d    = S_ORIG;
                        orig_cnt_d = 5'd0;
                        dup_cnt_d  = 5'd0;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The outputs are decoded from the next state, so they are valid in
        // the same cycle the state becomes visible.
        exec_dup_d   = (state_d == S_DUP);
        hold_fetch_d = (state_d == S_DRAIN);
        qed_check_d  = (state_d == S_DRAIN) && (drain_d == 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            orig_cnt_q   <= 5'd0;
            dup_cnt_q    <= 5'd0;
            drain_q      <= 4'd0;
            exec_dup_q   <= 1'b0;
            hold_fetch_q <= 1'b0;
            qed_check_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            orig_cnt_q   <= orig_cnt_d;
            dup_cnt_q    <= dup_cnt_d;
            drain_q      <= drain_d;
            exec_dup_q   <= exec_dup_d;
            hold_fetch_q <= hold_fetch_d;
            qed_check_q  <= qed_check_d;
        end
    end

    assign bus.exec_dup   = exec_dup_q;
    assign bus.hold_fetch = hold_fetch_q;
    assign bus.qed_check  = qed_check_q;
    assign bus.orig_cnt   = orig_cnt_q;
    assign bus.dup_cnt    = dup_cnt_q;

endmodule

// File: doc/qed_dup_sequencer.md
QED_DUP_SEQUENCER -- requirements
Module: qed_dup_sequencer

Interface
REQ-001 SHALL have parameter MAX_ORIG, default 16: originals per QED batch; legal range 1..31.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 5: pipeline drain length after a duplicate batch; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port ena, input, 1 bit: QED mode enable, the same signal driven to the qed block.
REQ-006 SHALL have port stall_IF, input, 1 bit: fetch stall; no instruction is accepted while high.
REQ-007 SHALL have port fetch_vld, input, 1 bit: an original instruction is presented by the IFU this cycle.
REQ-008 SHALL have port vld_out, input, 1 bit: the qed block holds a valid cached instruction for duplication.
REQ-009 SHALL have port force_dup, input, 1 bit: request to end the original batch early.
REQ-010 SHALL have port exec_dup, output, 1 bit: duplicate-mode select driven to the qed block.
REQ-011 SHALL have port hold_fetch, output, 1 bit: fetch hold request, asserted during DRAIN.
REQ-012 SHALL have port qed_check, output, 1 bit: one-cycle pulse; original and duplicate register halves may be compared.
REQ-013 SHALL have port orig_cnt, output, 5 bits: originals accepted in the current batch.
REQ-014 SHALL have port dup_cnt, output, 5 bits: duplicates issued in the current batch.

Function
REQ-015 SHALL implement FSM states IDLE, ORIG, DUP and DRAIN, with every output registered.
REQ-016 Accept events SHALL be defined as: acc_o = fetch_vld & !stall_IF; acc_d = vld_out & !stall_IF.
REQ-017 IDLE: exec_dup=0; when ena=1, SHALL move to ORIG next cycle and clear orig_cnt and dup_cnt.
REQ-018 ORIG: exec_dup=0; acc_o SHALL increment orig_cnt by 1; acc_d SHALL be ignored.
REQ-019 ORIG SHALL move to DUP (exec_dup=1 from the next cycle) when an acc_o brings orig_cnt to MAX_ORIG.
REQ-020 ORIG SHALL also move to DUP when force_dup=1 and the updated orig_cnt (including the same-cycle acc_o) is at least 1.
REQ-021 force_dup with updated orig_cnt=0 SHALL be ignored.
REQ-022 ORIG with ena=0 and orig_cnt=0 SHALL return to IDLE; with ena=0 and orig_cnt>0 it SHALL move to DUP (batch is always completed).
REQ-023 DUP: exec_dup=1; acc_d SHALL increment dup_cnt; acc_o SHALL be ignored; ena and force_dup SHALL be ignored.
REQ-024 DUP SHALL move to DRAIN when an acc_d makes dup_cnt equal orig_cnt; exec_dup SHALL be 0 from the next cycle.
REQ-025 DRAIN: hold_fetch=1 for exactly DRAIN_CYCLES cycles, using an internal 4-bit down-counter loaded with DRAIN_CYCLES-1 on entry.
REQ-026 In the last DRAIN cycle, qed_check SHALL pulse for one cycle; the next state SHALL be ORIG (counters cleared) if ena=1, else IDLE.
REQ-027 stall_IF in DRAIN SHALL NOT extend the drain.
REQ-028 Counters SHALL never exceed MAX_ORIG; no wrap-around is permitted.
REQ-029 exec_dup and hold_fetch SHALL never both be 1 in the same cycle.

Reset
REQ-030 While rst=0: state=IDLE; exec_dup=0, hold_fetch=0, qed_check=0, orig_cnt=0, dup_cnt=0, drain counter=0.
REQ-031 Reset asserted mid-batch (any state) SHALL abort immediately with no qed_check pulse.
REQ-032 After rst deassertion, the first state change SHALL occur at the first rising clk edge with ena=1.

Verification
REQ-033 Full batch: MAX_ORIG=16, ena=1, 16 acc_o -> exec_dup=1 on the following cycle; 16 acc_d -> exec_dup=0; hold_fetch high 5 cycles; one qed_check pulse; orig_cnt=dup_cnt=16 at that pulse.
REQ-034 Early end: 3 acc_o, then force_dup -> DUP; exactly 3 acc_d -> DRAIN; qed_check fires; force_dup with orig_cnt=0 -> stays in ORIG.
REQ-035 Stall: stall_IF=1 with fetch_vld=1 for 4 cycles -> orig_cnt unchanged; in DUP, stall_IF=1 with vld_out=1 -> dup_cnt unchanged.
REQ-036 ena drop: ena=0 after 5 originals -> 5 duplicates, drain, qed_check, then IDLE; ena=0 at orig_cnt=0 -> IDLE next cycle.
REQ-037 Reset mid-DUP: dup_cnt=7, rst=0 asynchronously -> all outputs 0 immediately; no qed_check pulse.
REQ-038 Same-cycle event: acc_o and force_dup together at orig_cnt=0 -> orig_cnt=1, DUP entered; 1 duplicate completes the batch.
